// File: rtl/roughness_mc.sv
// Multichannel roughness extractor: rectify, modulate, 2nd-order IIR, decimate.
// All channels share one multiplier and one MAC sequencer, 7 cycles per channel.
module roughness_mc #(
  parameter int unsigned DW   = 16,
  parameter int unsigned CW   = 18,
  parameter int unsigned NCH  = 4,
  parameter int unsigned DECW = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic [NCH*DW-1:0]   mod_data,
  input  logic [CW-1:0]       b0,
  input  logic [CW-1:0]       b1,
  input  logic [CW-1:0]       b2,
  input  logic [CW-1:0]       a1,
  input  logic [CW-1:0]       a2,
  input  logic                filt_en,
  input  logic [DECW-1:0]     decim_rate,
  output logic                busy,
  output logic                overrun,
  output logic                out_valid,
  output logic [NCH*DW-1:0]   out_data
);

  localparam int unsigned AW  = DW + CW + 3;
  localparam int unsigned PW  = DW + CW;
  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RECT, S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4, S_UPD, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [NCH*DW-1:0]      x_lat, m_lat;
  logic signed [CW-1:0]   b0_q, b1_q, b2_q, a1_q, a2_q;
  logic                   filt_en_q;
  logic [DECW-1:0]        rate_q;
  logic [CHW-1:0]         ch;
  logic signed [DW-1:0]   p_q;
  logic signed [AW-1:0]   acc;
  logic signed [DW-1:0]   x1 [NCH];
  logic signed [DW-1:0]   x2 [NCH];
  logic signed [DW-1:0]   y1 [NCH];
  logic signed [DW-1:0]   y2 [NCH];
  logic signed [DW-1:0]   res [NCH];
  logic [DECW-1:0]        fc;

  logic signed [DW-1:0]   x_cur_c, m_cur_c, r_c;
  logic signed [CW-1:0]   mul_a_c;
  logic signed [DW-1:0]   mul_b_c;
  logic                   sub_c;
  logic signed [PW-1:0]   prod_c;
  logic signed [AW-1:0]   prod_ext_c, p_shift_c, y_shift_c;
  logic                   last_ch_c;
  logic [DECW-1:0]        rate_eff_c, fc_inc_c;

  // Clamp a wide signed value into DW bits without wrapping.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [AW-1:0] v);
    if (!v[AW-1] && (|v[AW-2:DW-1]))
      sat_dw = {1'b0, {(DW-1){1'b1}}};
    else if (v[AW-1] && !(&v[AW-2:DW-1]))
      sat_dw = {1'b1, {(DW-1){1'b0}}};
    else
      sat_dw = v[DW-1:0];
  endfunction

  // Shared datapath: current channel operands, rectifier, multiplier, shifts.
  always_comb begin
    x_cur_c = x_lat[int'(ch)*DW +: DW];
    m_cur_c = m_lat[int'(ch)*DW +: DW];
    if (x_cur_c == {1'b1, {(DW-1){1'b0}}})
      r_c = {1'b0, {(DW-1){1'b1}}};
    else if (x_cur_c[DW-1])
      r_c = -x_cur_c;
    else
      r_c = x_cur_c;
    prod_c     = mul_a_c * mul_b_c;
    prod_ext_c = {{(AW-PW){prod_c[PW-1]}}, prod_c};
    p_shift_c  = prod_ext_c >>> (DW-1);
    y_shift_c  = acc >>> (CW-2);
    last_ch_c  = (ch == CHW'(NCH-1));
    rate_eff_c = (rate_q == '0) ? DECW'(1) : rate_q;
    fc_inc_c   = fc + DECW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_RECT;
      S_RECT:  state_nxt = S_MAC0;
      S_MAC0:  state_nxt = S_MAC1;
      S_MAC1:  state_nxt = S_MAC2;
      S_MAC2:  state_nxt = S_MAC3;
      S_MAC3:  state_nxt = S_MAC4;
      S_MAC4:  state_nxt = S_UPD;
      S_UPD:   state_nxt = last_ch_c ? S_DONE : S_RECT;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Multiplier operand steering; feedback terms are subtracted.
  always_comb begin
    mul_a_c = '0;
    mul_b_c = '0;
    sub_c   = 1'b0;
    case (state)
      S_RECT: begin mul_a_c = CW'(r_c); mul_b_c = m_cur_c; end
      S_MAC0: begin mul_a_c = b0_q; mul_b_c = p_q;    end
      S_MAC1: begin mul_a_c = b1_q; mul_b_c = x1[ch]; end
      S_MAC2: begin mul_a_c = b2_q; mul_b_c = x2[ch]; end
      S_MAC3: begin mul_a_c = a1_q; mul_b_c = y1[ch]; sub_c = 1'b1; end
      S_MAC4: begin mul_a_c = a2_q; mul_b_c = y2[ch]; sub_c = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      x_lat     <= '0;
      m_lat     <= '0;
      b0_q      <= '0;
      b1_q      <= '0;
      b2_q      <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      filt_en_q <= 1'b0;
      rate_q    <= '0;
      ch        <= '0;
      p_q       <= '0;
      acc       <= '0;
      fc        <= '0;
      for (int c = 0; c < NCH; c++) begin
        x1[c]  <= '0;
        x2[c]  <= '0;
        y1[c]  <= '0;
        y2[c]  <= '0;
        res[c] <= '0;
      end
    end else begin
      busy      <= (state_nxt != S_IDLE);
      overrun   <= in_valid && (state != S_IDLE);
      out_valid <= 1'b0;
      case (state)
        S_IDLE: if (in_valid) begin
          x_lat     <= in_data;
          m_lat     <= mod_data;
          b0_q      <= b0;
          b1_q      <= b1;
          b2_q      <= b2;
          a1_q      <= a1;
          a2_q      <= a2;
          filt_en_q <= filt_en;
          rate_q    <= decim_rate;
          ch        <= '0;
        end
        S_RECT: begin
          p_q <= sat_dw(p_shift_c);
          acc <= '0;
        end
        S_MAC0, S_MAC1, S_MAC2, S_MAC3, S_MAC4:
          acc <= sub_c ? (acc - prod_ext_c) : (acc + prod_ext_c);
        S_UPD: begin
          if (filt_en_q) begin
            x2[ch]  <= x1[ch];
            x1[ch]  <= p_q;
            y2[ch]  <= y1[ch];
            y1[ch]  <= sat_dw(y_shift_c);
            res[ch] <= sat_dw(y_shift_c);
          end else begin
            x1[ch]  <= '0;
            x2[ch]  <= '0;
            y1[ch]  <= '0;
            y2[ch]  <= '0;
            res[ch] <= p_q;
          end
          ch <= last_ch_c ? '0 : ch + CHW'(1);
        end
        S_DONE: begin
          if (fc == '0) begin
            for (int c = 0; c < NCH; c++) out_data[c*DW +: DW] <= res[c];
            out_valid <= 1'b1;
          end
          fc <= (fc_inc_c >= rate_eff_c) ? '0 : fc_inc_c;
        end
        default: ;
      endcase
    end
  end

endmodule
